// File: rtl/dec3x8_pkg.sv
// Shared types and helpers for the registered 3-to-8 pulse decoder.
package dec3x8_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } dec3x8_state_t;

  localparam int CNT_W = 8;

  function automatic logic [7:0] onehot8(input logic [2:0] code);
    return 8'b1 << code;
  endfunction

endpackage

// File: rtl/dec3x8_comb.sv
// Purely combinational 3-to-8 one-hot decode; the caller registers the result.
module dec3x8_comb
  import dec3x8_pkg::*;
(
  input  logic [2:0] code,
  output logic [7:0] onehot
);

  assign onehot = onehot8(code);

endmodule

// File: rtl/decoder3x8_pulse.sv
// Registered 3-to-8 decoder: accepts a code over valid/ready, drives Y[code] for PULSE_LEN cycles,
// then idles GAP_LEN cycles. Optional parity rejection is built when DEC3X8_PARITY_EN is defined.
module decoder3x8_pulse
  import dec3x8_pkg::*;
#(
  parameter int unsigned PULSE_LEN = 4,
  parameter int unsigned GAP_LEN   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_code,
  input  logic       in_par,
  output logic [7:0] Y,
  output logic       busy,
  output logic       done,
  output logic       par_err
);

  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = (GAP_LEN > 0) ? CNT_W'(GAP_LEN - 1) : '0;

  dec3x8_state_t    state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [7:0]       y_nxt;
  logic [7:0]       code_hot;
  logic             done_nxt;
  logic             perr_nxt;
  logic             ready_nxt;
  logic             transfer;
  logic             code_ok;

  dec3x8_comb u_comb (
    .code   (in_code),
    .onehot (code_hot)
  );

  assign transfer = in_valid && in_ready;

`ifdef DEC3X8_PARITY_EN
  assign code_ok = ~(^{in_par, in_code});
`else
  logic unused_par;
  assign unused_par = in_par;
  assign code_ok    = 1'b1;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    y_nxt     = Y;
    done_nxt  = 1'b0;
    perr_nxt  = 1'b0;
    case (state)
      IDLE: begin
        y_nxt = '0;
        if (transfer) begin
          if (code_ok) begin
            state_nxt = DRIVE;
            y_nxt     = code_hot;
            cnt_nxt   = PULSE_LOAD;
          end else begin
            perr_nxt = 1'b1;
          end
        end
      end
      DRIVE: begin
        if (cnt == '0) begin
          y_nxt    = '0;
          done_nxt = 1'b1;
          if (GAP_LEN > 0) begin
            state_nxt = GAP;
            cnt_nxt   = GAP_LOAD;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      GAP: begin
        y_nxt = '0;
        if (cnt == '0) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        y_nxt     = '0;
      end
    endcase
    // Ready is registered, so it reflects where the FSM lands after this edge.
    ready_nxt = (state_nxt == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      Y        <= '0;
      done     <= 1'b0;
      par_err  <= 1'b0;
      in_ready <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      Y        <= y_nxt;
      done     <= done_nxt;
      par_err  <= perr_nxt;
      in_ready <= ready_nxt;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_decoder3x8_pulse.sv
// Bench for decoder3x8_pulse: three instances (4/1, 1/0, 8/0) checked every cycle against a
// timeline model that counts edges since the last accepted code, plus directed literal checks.
module tb_decoder3x8_pulse;

  localparam int N   = 3;
  localparam int BIG = 1000;
`ifdef DEC3X8_PARITY_EN
  localparam bit PARITY_ON = 1'b1;
`else
  localparam bit PARITY_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic [N-1:0] rstn_v, valid_v, par_v, ready_v, busy_v, done_v, perr_v;
  logic [2:0]   code_a [N];
  logic [7:0]   y_a    [N];

  int       plen    [N] = '{4, 1, 8};
  int       glen    [N] = '{1, 0, 0};
  int       m_t     [N] = '{BIG, BIG, BIG};
  logic [2:0] m_code [N] = '{3'd0, 3'd0, 3'd0};
  bit       m_ready [N] = '{1'b0, 1'b0, 1'b0};
  bit       m_perr  [N] = '{1'b0, 1'b0, 1'b0};

  int n_vec = 0;
  int n_err = 0;
  int waited;
  longint t_prev, t_now;

  always #5 clk = ~clk;

  decoder3x8_pulse #(.PULSE_LEN(4), .GAP_LEN(1)) dut0 (
    .clk(clk), .rst_n(rstn_v[0]), .in_valid(valid_v[0]), .in_ready(ready_v[0]),
    .in_code(code_a[0]), .in_par(par_v[0]), .Y(y_a[0]), .busy(busy_v[0]),
    .done(done_v[0]), .par_err(perr_v[0]));

  decoder3x8_pulse #(.PULSE_LEN(1), .GAP_LEN(0)) dut1 (
    .clk(clk), .rst_n(rstn_v[1]), .in_valid(valid_v[1]), .in_ready(ready_v[1]),
    .in_code(code_a[1]), .in_par(par_v[1]), .Y(y_a[1]), .busy(busy_v[1]),
    .done(done_v[1]), .par_err(perr_v[1]));

  decoder3x8_pulse #(.PULSE_LEN(8), .GAP_LEN(0)) dut2 (
    .clk(clk), .rst_n(rstn_v[2]), .in_valid(valid_v[2]), .in_ready(ready_v[2]),
    .in_code(code_a[2]), .in_par(par_v[2]), .Y(y_a[2]), .busy(busy_v[2]),
    .done(done_v[2]), .par_err(perr_v[2]));

  task automatic checkOutput(input string name, input int inst,
                             input logic [31:0] actual, input logic [31:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_err++;
      $display("[TB] FAIL %s inst%0d at %0t: got %0h, want %0h", name, inst, $time, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int inst, input bit v, input logic [2:0] c, input bit p);
    valid_v[inst] = v;
    code_a[inst]  = c;
    par_v[inst]   = p;
  endtask

  // Present a code and return just after the accepting edge (negedge + 1).
  task automatic sendCode(input int inst, input logic [2:0] c, input bit p, input bit keep,
                          output int cycles);
    applyStimulus(inst, 1'b1, c, p);
    cycles = 0;
    while (!ready_v[inst] && cycles < 100) begin
      @(negedge clk); #1;
      cycles++;
    end
    if (cycles >= 100) checkOutput("accept_timeout", inst, 32'(ready_v[inst]), 32'd1);
    @(negedge clk);
    if (!keep) valid_v[inst] = 1'b0;
    #1;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Model: asynchronous reset returns each lane to an idle, not-ready timeline.
  always @(rstn_v) begin
    for (int i = 0; i < N; i++) begin
      if (!rstn_v[i]) begin
        m_t[i]     = BIG;
        m_ready[i] = 1'b0;
        m_perr[i]  = 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rstn_v[i]) begin
        m_perr[i] = 1'b0;
        if (m_ready[i] && valid_v[i]) begin
          if (PARITY_ON && (^{par_v[i], code_a[i]})) begin
            m_perr[i] = 1'b1;
          end else begin
            m_code[i] = code_a[i];
            m_t[i]    = 0;
          end
        end else if (m_t[i] < BIG) begin
          m_t[i]++;
        end
        m_ready[i] = (m_t[i] >= plen[i] + glen[i]);
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      checkOutput("y", i, 32'(y_a[i]), (m_t[i] < plen[i]) ? 32'(8'd1 << m_code[i]) : 32'd0);
      checkOutput("in_ready", i, 32'(ready_v[i]), 32'(m_ready[i]));
      checkOutput("busy", i, 32'(busy_v[i]), 32'(m_t[i] < plen[i] + glen[i]));
      checkOutput("done", i, 32'(done_v[i]), 32'(m_t[i] == plen[i]));
      checkOutput("par_err", i, 32'(perr_v[i]), 32'(m_perr[i]));
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rstn_v  = '1;
    valid_v = '0;
    par_v   = '0;
    for (int i = 0; i < N; i++) code_a[i] = 3'd0;
    #1 rstn_v = '0;

    // Reset held for three cycles.
    step(3);
    for (int i = 0; i < N; i++) begin
      checkOutput("rst_y", i, 32'(y_a[i]), 32'd0);
      checkOutput("rst_ready", i, 32'(ready_v[i]), 32'd0);
      checkOutput("rst_busy", i, 32'(busy_v[i]), 32'd0);
      checkOutput("rst_done", i, 32'(done_v[i]), 32'd0);
    end
    @(posedge clk); #2 rstn_v = '1;
    #1 checkOutput("ready_pre_edge", 0, 32'(ready_v[0]), 32'd0);
    @(posedge clk);
    @(negedge clk); #1;
    checkOutput("ready_after_release", 0, 32'(ready_v[0]), 32'd1);

    // Sweep codes 0..7 with in_valid held; spacing must be 6 cycles.
    t_prev = 0;
    for (int n = 0; n < 8; n++) begin
      logic [2:0] c;
      c = 3'(n);
      sendCode(0, c, ^c, 1'b1, waited);
      t_now = $time;
      if (n > 0) checkOutput("sweep_spacing", 0, 32'((t_now - t_prev) / 10), 32'd6);
      t_prev = t_now;
      checkOutput("sweep_y", 0, 32'(y_a[0]), 32'(8'd1 << c));
      if (n == 5) checkOutput("code5_y", 0, 32'(y_a[0]), 32'h20);
      for (int k = 1; k < 4; k++) begin
        step(1);
        checkOutput("sweep_hold", 0, 32'(y_a[0]), 32'(8'd1 << c));
      end
      step(1);
      checkOutput("sweep_clear", 0, 32'(y_a[0]), 32'd0);
      checkOutput("sweep_done", 0, 32'(done_v[0]), 32'd1);
    end
    valid_v[0] = 1'b0;

    // Back-to-back with PULSE_LEN=1, GAP_LEN=0 and in_valid held.
    sendCode(1, 3'd3, 1'b0, 1'b1, waited);
    checkOutput("b2b_y3", 1, 32'(y_a[1]), 32'h08);
    checkOutput("b2b_busy", 1, 32'(busy_v[1]), 32'd1);
    applyStimulus(1, 1'b1, 3'd7, 1'b1);
    step(1);
    checkOutput("b2b_gap_y", 1, 32'(y_a[1]), 32'd0);
    checkOutput("b2b_ready", 1, 32'(ready_v[1]), 32'd1);
    step(1);
    checkOutput("b2b_y7", 1, 32'(y_a[1]), 32'h80);
    valid_v[1] = 1'b0;
    step(3);

    // Reset two cycles into an 8-cycle pulse, then a clean pulse afterwards.
    sendCode(2, 3'd6, 1'b0, 1'b0, waited);
    checkOutput("mid_y6", 2, 32'(y_a[2]), 32'h40);
    @(posedge clk);
    @(posedge clk); #2 rstn_v[2] = 1'b0;
    #1 checkOutput("mid_async_y", 2, 32'(y_a[2]), 32'd0);
    checkOutput("mid_async_busy", 2, 32'(busy_v[2]), 32'd0);
    repeat (2) @(posedge clk);
    #2 rstn_v[2] = 1'b1;
    step(1);
    sendCode(2, 3'd2, 1'b1, 1'b0, waited);
    for (int k = 0; k < 8; k++) begin
      checkOutput("post_rst_y2", 2, 32'(y_a[2]), 32'h04);
      step(1);
    end
    checkOutput("post_rst_clear", 2, 32'(y_a[2]), 32'd0);
    checkOutput("post_rst_done", 2, 32'(done_v[2]), 32'd1);

    // Bad parity on code 3, then good parity.
    step(3);
    sendCode(0, 3'b011, 1'b1, 1'b0, waited);
`ifdef DEC3X8_PARITY_EN
    checkOutput("par_err_pulse", 0, 32'(perr_v[0]), 32'd1);
    checkOutput("par_y", 0, 32'(y_a[0]), 32'd0);
    checkOutput("par_ready", 0, 32'(ready_v[0]), 32'd1);
`else
    checkOutput("nopar_y", 0, 32'(y_a[0]), 32'h08);
    checkOutput("nopar_err", 0, 32'(perr_v[0]), 32'd0);
`endif
    sendCode(0, 3'b011, 1'b0, 1'b0, waited);
    checkOutput("good_par_y", 0, 32'(y_a[0]), 32'h08);
    step(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/decoder3x8_pulse.md
# decoder3x8_pulse

Registered 3-to-8 decoder with pulse generation. It accepts a 3-bit binary code over a valid/ready handshake and drives the matching one-hot line of `Y` high for a programmable number of cycles. It then enforces a programmable idle gap before it accepts the next code. It is the receive-side counterpart of the 8x3 encoder: it turns encoded indices back into one-hot strobes for downstream select/enable logic.

## Interface
Parameters:
- `PULSE_LEN`, default 4: cycles `Y` stays one-hot per accepted code. Legal range 1..255.
- `GAP_LEN`, default 1: forced idle cycles after each pulse, in addition to the mandatory IDLE cycle. Legal range 0..255.

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  `in_code` is valid
- `in_ready`  out  1  block can accept a code; registered
- `in_code`  in  3  binary index 0..7
- `in_par`  in  1  even-parity bit over `in_code`; used only with `DEC3X8_PARITY_EN`
- `Y`  out  8  one-hot output, `Y[in_code]`; registered
- `busy`  out  1  high in DRIVE or GAP
- `done`  out  1  one-cycle pulse when a pulse completes
- `par_err`  out  1  one-cycle pulse on a rejected code

## Operation
- The FSM has three states: IDLE, DRIVE and GAP.
- **Handshake:** a transfer occurs at a rising edge where `in_valid && in_ready`. `in_code` and `in_par` are sampled only then.
- **IDLE:**
  - `in_ready`=1, `Y`=0, `busy`=0.
  - On a transfer: go to DRIVE, set `Y` to `8'b1 << in_code`, load the counter with `PULSE_LEN-1`.
- **DRIVE:**
  - `in_ready`=0, `busy`=1, `Y` is held.
  - The counter decrements each cycle.
  - At counter 0: clear `Y` and assert `done`. Go to GAP with counter `GAP_LEN-1` if `GAP_LEN`>0, else go to IDLE.
- **GAP:**
  - `Y`=0, `busy`=1, `in_ready`=0.
  - At counter 0, go to IDLE.
- `in_valid` asserted outside IDLE is ignored; nothing is queued. The source must hold `in_valid` and `in_code` until `in_ready`.
- The counter width is 8 bits, with no wrap in legal configurations.
- `Y` is always zero or exactly one-hot. It never holds two bits.
- **Reset:** `rst_n` low, at any time including mid-pulse, immediately forces:
  - state IDLE and counter 0
  - `Y`=0, `done`=0, `par_err`=0, `busy`=0, `in_ready`=0

  `in_ready` rises at the first clock edge after `rst_n` is released.

## Timing
- Edges are numbered from the transfer edge E0.
- `Y` is one-hot from after E0 through E(PULSE_LEN-1). `Y`=0 after E(PULSE_LEN).
- `done`=1 for exactly the cycle after E(PULSE_LEN).
- `in_ready` is 1 again after E(PULSE_LEN+GAP_LEN).
- With `in_valid` held high, the minimum accept-to-accept spacing is PULSE_LEN+GAP_LEN+1 cycles.
- Latency from transfer edge to `Y` valid is 1 cycle. There is no combinational path from inputs to outputs.

## Configuration
- **`DEC3X8_PARITY_EN` defined:**
  - At each transfer, `^{in_par, in_code}` must be 0.
  - If it is 1, the code is consumed but no pulse is produced. The state stays IDLE, `par_err`=1 for the cycle after the transfer edge, `done` stays 0, and `in_ready` stays 1.
- **`DEC3X8_PARITY_EN` undefined:**
  - `in_par` is ignored and `par_err` is tied to 0.
  - Every transfer produces a pulse.

## Structure
- **Package `dec3x8_pkg`:**
  - state enum `dec3x8_state_t` (IDLE, DRIVE, GAP)
  - `CNT_W`=8
  - function `onehot8(input [2:0])`
- **Sub-module `dec3x8_comb`:** purely combinational 3-to-8 one-hot decode. The top-level registers its output into `Y`.

## Test plan
- **Reset:** hold `rst_n`=0 for 3 cycles.
  - Expect `Y`=0, `in_ready`=0, `busy`=0, `done`=0.
  - Expect `in_ready`=1 one edge after release.
- **Sweep:** with PULSE_LEN=4 and GAP_LEN=1, send codes 0..7.
  - For each code n, expect `Y`=`1<<n` (e.g. code 5 gives `8'b00100000`) for exactly 4 cycles.
  - Expect `done` high 1 cycle, then 1 GAP cycle plus 1 IDLE cycle before the next accept (6-cycle spacing).
- **Back-to-back and hold:** with PULSE_LEN=1 and GAP_LEN=0, hold `in_valid`=1 while alternating code 3 and code 7.
  - Expect one-cycle pulses `8'b00001000` then `8'b10000000`, 2 cycles apart.
  - Expect no acceptance while `busy`=1.
- **Reset mid-pulse:** with PULSE_LEN=8, send code 6 and assert `rst_n`=0 two cycles into DRIVE.
  - Expect `Y` to drop to 0 asynchronously, with no `done`.
  - After release, send code 2 and expect a normal 8-cycle `8'b00000100`.
- **Parity (`DEC3X8_PARITY_EN`):** send `in_code`=3'b011 with `in_par`=1.
  - Expect `par_err` pulse, `Y`=0, `in_ready` stays 1.
  - Then send 3'b011 with `in_par`=0 and expect a normal pulse on `Y[3]`.
- **Parity disabled:** send the same bad parity with the macro undefined.
  - Expect the pulse on `Y[3]` and `par_err`=0.
